// File: rtl/alu_serial_buffer.sv
// Byte-wide operand feed and result collector around the ALU's serial data ports.
// Define ALU_SERIAL_BUFFER_ERR_EN to track sticky {overflow, underflow} flags on err.
module alu_serial_buffer #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [REG_BITS-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                pair_op,
  output logic                operand_ready,
  input  logic                active,
  output logic [NSHIFT-1:0]   data_in,
  input  logic                capture,
  input  logic [NSHIFT-1:0]   data_out,
  output logic [REG_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          err
);

  localparam int STEPS = REG_BITS / NSHIFT;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  logic [REG_BITS-1:0] head_q, head_d;
  logic [REG_BITS-1:0] tail_q, tail_d;
  logic [1:0]          in_cnt_q, in_cnt_d;
  logic [SW-1:0]       step_in_q, step_in_d;
  logic [REG_BITS-1:0] coll_q, coll_d;
  logic [SW-1:0]       step_out_q, step_out_d;
  logic [REG_BITS-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic                accept;
  logic                shift_en;
  logic                pop;
  logic                complete;
  logic [REG_BITS-1:0] coll_shift;

  assign in_ready      = (in_cnt_q != 2'd2);
  assign accept        = in_valid && in_ready;
  assign shift_en      = active && (in_cnt_q != 2'd0);
  assign pop           = shift_en && (step_in_q == LAST_STEP);
  assign operand_ready = pair_op ? (in_cnt_q == 2'd2) : (in_cnt_q != 2'd0);
  assign data_in       = (in_cnt_q == 2'd0) ? '0 : head_q[NSHIFT-1:0];

  assign coll_shift = {data_out, coll_q[REG_BITS-1:NSHIFT]};
  assign complete   = active && capture && (step_out_q == LAST_STEP);

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // Input FIFO: the head is consumed in place by shifting, the tail waits behind it.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    in_cnt_d  = in_cnt_q;
    step_in_d = step_in_q;
    if (flush) begin
      head_d    = '0;
      tail_d    = '0;
      in_cnt_d  = 2'd0;
      step_in_d = '0;
    end else begin
      if (shift_en) begin
        head_d    = head_q >> NSHIFT;
        step_in_d = step_in_q + SW'(1);
      end
      if (pop) begin
        step_in_d = '0;
        if (in_cnt_q == 2'd2) begin
          head_d   = tail_q;
          in_cnt_d = 2'd1;
        end else if (accept) begin
          head_d   = in_data;
          in_cnt_d = 2'd1;
        end else begin
          head_d   = '0;
          in_cnt_d = 2'd0;
        end
      end else if (accept) begin
        if (in_cnt_q == 2'd0) begin
          head_d = in_data;
        end else begin
          tail_d = in_data;
        end
        in_cnt_d = in_cnt_q + 2'd1;
      end
    end
  end

  // Result collector: slices enter at the MSB so the first slice ends up at bit 0.
  always_comb begin
    coll_d      = coll_q;
    step_out_d  = step_out_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      coll_d      = '0;
      step_out_d  = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (active && capture) begin
        coll_d     = coll_shift;
        step_out_d = step_out_q + SW'(1);
        if (complete) begin
          step_out_d  = '0;
          out_data_d  = coll_shift;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      in_cnt_q    <= 2'd0;
      step_in_q   <= '0;
      coll_q      <= '0;
      step_out_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_cnt_q    <= in_cnt_d;
      step_in_q   <= step_in_d;
      coll_q      <= coll_d;
      step_out_q  <= step_out_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ALU_SERIAL_BUFFER_ERR_EN
  logic [1:0] err_q, err_d;
  logic       underflow;
  logic       overflow;

  assign underflow = active && (in_cnt_q == 2'd0);
  assign overflow  = complete && out_valid_q && !out_ready;

  always_comb begin
    err_d = err_q | {overflow, underflow};
    if (flush) begin
      err_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif

endmodule

// File: tb/tb_alu_serial_buffer.sv
// Scoreboard bench for alu_serial_buffer: operand slices and result bytes are queued
// as stimulus is driven and compared when the DUT presents them.
module tb_alu_serial_buffer;

`ifdef ALU_SERIAL_BUFFER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       pair_op;
  logic       operand_ready;
  logic       active;
  logic [1:0] data_in;
  logic       capture;
  logic [1:0] data_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] err;

  int n_compared;
  int n_mismatched;

  logic [1:0] sb_in[$];
  logic [7:0] sb_out[$];
  logic [7:0] coll_m;
  int         cap_cnt;
  logic [1:0] exp_err;
  logic       acc;

  alu_serial_buffer #(.REG_BITS(8), .NSHIFT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pair_op      (pair_op),
    .operand_ready(operand_ready),
    .active       (active),
    .data_in      (data_in),
    .capture      (capture),
    .data_out     (data_out),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_model();
    sb_in.delete();
    sb_out.delete();
    coll_m  = 8'h00;
    cap_cnt = 0;
    exp_err = 2'b00;
  endtask

  // One clock cycle: check outputs against the model, update the model, drive, advance.
  task automatic applyStep(input logic act, input logic cap, input logic [1:0] dout,
                           input logic ordy, input logic offer, input logic [7:0] b,
                           output logic accepted);
    int         cnt;
    logic [1:0] exp_slice;
    logic       completing;
    cnt = (sb_in.size() + 3) / 4;
    exp_slice = 2'd0;
    if (cnt > 0) exp_slice = sb_in[0];
    checkOutput("in_ready", in_ready, (cnt < 2));
    checkOutput("operand_ready", operand_ready, (cnt >= (pair_op ? 2 : 1)));
    checkOutput("data_in", data_in, exp_slice);
    checkOutput("err", err, exp_err);
    checkOutput("out_valid", out_valid, (sb_out.size() > 0));
    if (sb_out.size() > 0) checkOutput("out_data", out_data, sb_out[0]);

    if (act) begin
      if (cnt > 0) void'(sb_in.pop_front());
      else if (ERR_EN) exp_err[0] = 1'b1;
    end
    accepted = offer && (cnt < 2);
    if (accepted) begin
      for (int i = 0; i < 4; i++) sb_in.push_back(b[2*i +: 2]);
    end

    completing = 1'b0;
    if (act && cap) begin
      coll_m = {dout, coll_m[7:2]};
      cap_cnt++;
      if (cap_cnt == 4) begin
        cap_cnt    = 0;
        completing = 1'b1;
      end
    end
    if (sb_out.size() > 0 && (ordy || completing)) begin
      if (!ordy && ERR_EN) exp_err[1] = 1'b1;
      void'(sb_out.pop_front());
    end
    if (completing) sb_out.push_back(coll_m);

    active    = act;
    capture   = cap;
    data_out  = dout;
    out_ready = ordy;
    in_valid  = offer;
    in_data   = b;
    @(negedge clk);
    active    = 1'b0;
    capture   = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic a;
    applyStep(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, b, a);
  endtask

  task automatic run_steps(input int n);
    logic a;
    for (int i = 0; i < n; i++) applyStep(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, a);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    applyStep(1'b0, 1'b0, 2'd0, ordy, 1'b0, 8'h00, a);
  endtask

  task automatic capture_byte(input logic [7:0] b, input logic ordy);
    logic a;
    for (int i = 0; i < 4; i++) applyStep(1'b1, 1'b1, b[2*i +: 2], ordy, 1'b0, 8'h00, a);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_operand_ready"}, operand_ready, 0);
    checkOutput({tag, "_data_in"}, data_in, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    pair_op   = 1'b0;
    active    = 1'b0;
    capture   = 1'b0;
    data_out  = 2'd0;
    out_ready = 1'b0;
    clear_model();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single-byte operand 0xB4 streams 0,1,3,2.
    $display("[TB] single byte operand");
    pair_op = 1'b0;
    push_byte(8'hB4);
    run_steps(4);
    idle(1'b0);

    // Pair operand 0x34, 0x12: ready only once both bytes are in.
    $display("[TB] pair operand");
    pair_op = 1'b1;
    push_byte(8'h34);
    push_byte(8'h12);
    run_steps(8);
    idle(1'b0);

    // Offer a byte during the pop with the FIFO full, then with one entry left.
    $display("[TB] accept alongside pop");
    pair_op = 1'b0;
    push_byte(8'hC9);
    push_byte(8'h27);
    run_steps(3);
    applyStep(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h5A, acc);
    for (int tries = 0; tries < 4 && !acc; tries++)
      applyStep(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h5A, acc);
    checkOutput("offer_5A_accepted", acc, 1);
    run_steps(8);
    push_byte(8'h81);
    run_steps(3);
    applyStep(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h3C, acc);
    run_steps(4);
    idle(1'b0);

    // Collector: slices 2,3,0,1 form 0x4E, then an overflow with 0xFF.
    $display("[TB] collector and overflow");
    capture_byte(8'h4E, 1'b0);
    idle(1'b1);
    idle(1'b0);
    capture_byte(8'h4E, 1'b0);
    capture_byte(8'hFF, 1'b0);
    idle(1'b0);

    // Flush wins over accept and step in the same cycle.
    $display("[TB] flush");
    push_byte(8'h66);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    active   = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    active   = 1'b0;
    clear_model();
    idle(1'b0);

    // Asynchronous reset in the middle of a pair operand with a result pending.
    $display("[TB] async reset mid operand");
    pair_op = 1'b1;
    push_byte(8'h34);
    push_byte(8'h12);
    capture_byte(8'hA5, 1'b0);
    run_steps(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    pair_op = 1'b0;
    push_byte(8'hB4);
    run_steps(4);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
